// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush and capture of a memory response for a stalled head entry.
module pipe_stage_buffer #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int REQ_W  = 2,
    parameter int RESP_W = 32,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [REQ_W-1:0]  in_req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [REQ_W-1:0]  out_req,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_data,
    output logic              resp_held,
    output logic [RESP_W-1:0] resp_reg,
    output logic [1:0]        occupancy
);

    logic              head_valid_q, head_valid_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
    logic [REQ_W-1:0]  head_req_q, head_req_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [REQ_W-1:0]  skid_req_q, skid_req_d;
    logic              resp_held_q, resp_held_d;
    logic [RESP_W-1:0] resp_reg_q, resp_reg_d;

    logic accept;
    logic pop;
    logic capture;

    // With a skid entry, in_ready depends only on registered state
    assign in_ready = (SKID != 0) ? !skid_valid_q
                                  : (!head_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign pop      = head_valid_q && out_ready;
    assign capture  = head_valid_q && (|head_req_q) && resp_valid && !out_ready;

    assign out_valid = head_valid_q;
    assign out_data  = head_data_q;
    assign out_ctrl  = head_ctrl_q;
    assign out_req   = head_valid_q ? head_req_q : '0;
    assign resp_held = resp_held_q;
    assign resp_reg  = resp_reg_q;
    assign occupancy = {1'b0, head_valid_q} + {1'b0, skid_valid_q};

    always_comb begin
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        head_ctrl_d  = head_ctrl_q;
        head_req_d   = head_req_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_req_d   = skid_req_q;
        resp_held_d  = resp_held_q;
        resp_reg_d   = resp_reg_q;
        if (flush) begin
            head_valid_d = 1'b0;
            head_data_d  = '0;
            head_ctrl_d  = '0;
            head_req_d   = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
            skid_ctrl_d  = '0;
            skid_req_d   = '0;
            resp_held_d  = 1'b0;
            resp_reg_d   = '0;
        end else begin
            if (pop || !head_valid_q) begin
                if (skid_valid_q) begin
                    head_valid_d = 1'b1;
                    head_data_d  = skid_data_q;
                    head_ctrl_d  = skid_ctrl_q;
                    head_req_d   = skid_req_q;
                    skid_valid_d = accept;
                    if (accept) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        skid_req_d  = in_req;
                    end
                end else begin
                    head_valid_d = accept;
                    if (accept) begin
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                        head_req_d  = in_req;
                    end
                end
            end else begin
                if (accept) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = in_data;
                    skid_ctrl_d  = in_ctrl;
                    skid_req_d   = in_req;
                end
                // Retire the head's request so it is never reissued
                if (capture) head_req_d = '0;
            end
            if (capture) begin
                resp_held_d = 1'b1;
                resp_reg_d  = resp_data;
            end else if (pop) begin
                resp_held_d = 1'b0;
            end
        end
        if (SKID == 0) skid_valid_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
            head_ctrl_q  <= '0;
            head_req_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            skid_req_q   <= '0;
            resp_held_q  <= 1'b0;
            resp_reg_q   <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
            head_ctrl_q  <= head_ctrl_d;
            head_req_q   <= head_req_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_req_q   <= skid_req_d;
            resp_held_q  <= resp_held_d;
            resp_reg_q   <= resp_reg_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer (SKID=1): streaming, skid stall,
// response capture, flush and mid-stall reset.
module tb_pipe_stage_buffer;

    logic         CLK;
    logic         nRST;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [7:0]   in_ctrl;
    logic [1:0]   in_req;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [7:0]   out_ctrl;
    logic [1:0]   out_req;
    logic         resp_valid;
    logic [31:0]  resp_data;
    logic         resp_held;
    logic [31:0]  resp_reg;
    logic [1:0]   occupancy;

    int checks = 0;
    int errors = 0;

    pipe_stage_buffer #(
        .DATA_W(128), .CTRL_W(8), .REQ_W(2), .RESP_W(32), .SKID(1)
    ) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_req(in_req),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_req(out_req),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_held(resp_held), .resp_reg(resp_reg),
        .occupancy(occupancy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic offer(input logic [127:0] d, input logic [1:0] r);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = d[7:0];
        in_req   = r;
    endtask

    initial begin
        nRST = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; in_ctrl = '0; in_req = '0;
        out_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
        #2;
        check("rst_valid", 128'(out_valid), 128'd0);
        check("rst_occ", 128'(occupancy), 128'd0);
        check("rst_data", out_data, 128'd0);
        check("rst_held", 128'(resp_held), 128'd0);
        check("rst_reg", 128'(resp_reg), 128'd0);
        #10 nRST = 1'b1;
        step();
        check("rel_ready", 128'(in_ready), 128'd1);

        // 1: streaming, one per cycle, 1-cycle latency
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            offer(128'(i), 2'b00);
            step();
            check("str_valid", 128'(out_valid), 128'd1);
            check("str_data", out_data, 128'(i));
            check("str_occ", 128'(occupancy), 128'd1);
        end
        in_valid = 1'b0;
        step();
        check("str_drain", 128'(out_valid), 128'd0);
        check("str_hold", out_data, 128'd4);

        // 2: skid fill while stalled, then drain in order
        out_ready = 1'b0;
        offer(128'hA, 2'b00);
        step();
        check("sk_occ1", 128'(occupancy), 128'd1);
        check("sk_rdy1", 128'(in_ready), 128'd1);
        offer(128'hB, 2'b00);
        step();
        check("sk_occ2", 128'(occupancy), 128'd2);
        check("sk_rdy2", 128'(in_ready), 128'd0);
        check("sk_headA", out_data, 128'hA);
        offer(128'hC, 2'b00);
        step();
        check("sk_full", 128'(occupancy), 128'd2);
        check("sk_still", out_data, 128'hA);
        out_ready = 1'b1;
        step();
        check("sk_outB", out_data, 128'hB);
        check("sk_occB", 128'(occupancy), 128'd1);
        step();
        check("sk_outC", out_data, 128'hC);
        check("sk_vC", 128'(out_valid), 128'd1);
        in_valid = 1'b0;
        step();
        check("sk_empty", 128'(out_valid), 128'd0);
        check("sk_occ0", 128'(occupancy), 128'd0);

        // 3: capture on stalled head, later strobes ignored, pop clears
        out_ready = 1'b0;
        offer(128'h33, 2'b10);
        step();
        check("cap_req", 128'(out_req), 128'd2);
        in_valid = 1'b0;
        resp_valid = 1'b1; resp_data = 32'hDEADBEEF;
        step();
        check("cap_held", 128'(resp_held), 128'd1);
        check("cap_reg", 128'(resp_reg), 128'hDEADBEEF);
        check("cap_req0", 128'(out_req), 128'd0);
        check("cap_data", out_data, 128'h33);
        check("cap_ctrl", 128'(out_ctrl), 128'h33);
        resp_data = 32'h12345678;
        step();
        check("cap_again", 128'(resp_reg), 128'hDEADBEEF);
        resp_valid = 1'b0; out_ready = 1'b1;
        step();
        check("cap_pop", 128'(resp_held), 128'd0);
        check("cap_keep", 128'(resp_reg), 128'hDEADBEEF);
        check("cap_empty", 128'(out_valid), 128'd0);

        // 4: response with out_ready high is not captured
        offer(128'h44, 2'b01);
        step();
        check("nc_req", 128'(out_req), 128'd1);
        in_valid = 1'b0;
        resp_valid = 1'b1; resp_data = 32'hCAFEF00D;
        step();
        check("nc_held", 128'(resp_held), 128'd0);
        check("nc_reg", 128'(resp_reg), 128'hDEADBEEF);
        resp_valid = 1'b0;

        // 5: flush with full buffer and a captured response
        out_ready = 1'b0;
        offer(128'h51, 2'b10);
        step();
        offer(128'h52, 2'b01);
        resp_valid = 1'b1; resp_data = 32'hABCD0001;
        step();
        resp_valid = 1'b0;
        check("fl_occ2", 128'(occupancy), 128'd2);
        check("fl_held", 128'(resp_held), 128'd1);
        check("fl_reg", 128'(resp_reg), 128'hABCD0001);
        check("fl_hreq", 128'(out_req), 128'd0);
        offer(128'h53, 2'b11);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 128'(out_valid), 128'd0);
        check("fl_occ", 128'(occupancy), 128'd0);
        check("fl_req", 128'(out_req), 128'd0);
        check("fl_held0", 128'(resp_held), 128'd0);
        check("fl_reg0", 128'(resp_reg), 128'd0);
        check("fl_data", out_data, 128'd0);
        check("fl_rdy", 128'(in_ready), 128'd1);
        step();
        check("fl_absent", 128'(out_valid), 128'd0);

        // 6: reset mid-stall
        offer(128'h61, 2'b10);
        step();
        offer(128'h62, 2'b01);
        step();
        check("rs_occ2", 128'(occupancy), 128'd2);
        in_valid = 1'b0;
        nRST = 1'b0;
        #1;
        check("rs_valid", 128'(out_valid), 128'd0);
        check("rs_occ", 128'(occupancy), 128'd0);
        check("rs_data", out_data, 128'd0);
        check("rs_ctrl", 128'(out_ctrl), 128'd0);
        #1 nRST = 1'b1;
        #1;
        check("rs_rdy", 128'(in_ready), 128'd1);
        out_ready = 1'b1;
        offer(128'h70, 2'b00);
        step();
        check("rs_next_v", 128'(out_valid), 128'd1);
        check("rs_next_d", out_data, 128'h70);
        check("rs_next_o", 128'(occupancy), 128'd1);
        in_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
Parametrised inter-stage pipeline register for the multicore pipeline, generalising the fixed EX/MEM register. It carries payload, control and memory-request fields between stages using a valid/ready handshake, with an optional 2-entry skid buffer and synchronous flush. It also captures a memory response that arrives while the head entry is stalled and retires that entry's request bits, so a request is never reissued.

Parameters:
DATA_W, 128, payload width (pc, instr, alu result, operands), passed through unmodified.
CTRL_W, 8, control-field width (RegWr, MemtoReg, WriteSrc, halt, atomic...).
REQ_W, 2, memory-request bits (e.g. {MemRead, MemWr}); cleared once a response is captured.
RESP_W, 32, memory response width.
SKID, 1, 0 = single register; 1 = main + skid entry (full-throughput registered in_ready).

Ports:
CLK  input  1  clock, rising edge.
nRST  input  1  asynchronous active-low reset.
flush  input  1  synchronous flush; drops all held entries.
in_valid  input  1  upstream entry valid.
in_ready  output  1  stage can accept.
in_data  input  DATA_W  upstream payload.
in_ctrl  input  CTRL_W  upstream control.
in_req  input  REQ_W  upstream memory-request bits.
out_valid  output  1  head entry valid.
out_ready  input  1  downstream accepts head.
out_data  output  DATA_W  head payload.
out_ctrl  output  CTRL_W  head control.
out_req  output  REQ_W  head request bits (outstanding request).
resp_valid  input  1  memory response strobe (dhit).
resp_data  input  RESP_W  memory response data (dmemload).
resp_held  output  1  response captured for current head.
resp_reg  output  RESP_W  captured response data.
occupancy  output  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Reset (nRST low, asynchronous): all entries invalid; out_* = 0, resp_held = 0, resp_reg = 0, occupancy = 0. in_ready = 1 from the first cycle after release.
- Accept = in_valid & in_ready; pop = out_valid & out_ready. Latency is 1 cycle from accept to out_valid when the stage is empty.
- SKID=0: in_ready = !out_valid | out_ready (combinational from out_ready). On accept, the entry loads into head.
- SKID=1: in_ready = !skid_valid (registered; no combinational path from out_ready).
  - Accept with head free, or head popping: load into head.
  - Accept with head held and not popping: load into skid.
  - On pop with skid valid: skid moves to head; the new entry may land in skid in the same cycle.
  - Sustained valid/ready gives one transfer per cycle.
- Full (occupancy 2, SKID=1): in_ready = 0 and input is ignored; entries hold with no loss or duplication.
- Empty: out_valid = 0 and out_* hold their last values. out_req is forced to 0 whenever out_valid = 0.
- Response capture, evaluated on the head only:
  - Capture fires when out_valid & |out_req & resp_valid & !out_ready.
  - Next cycle: resp_reg = resp_data, resp_held = 1, head out_req = 0.
  - Head payload and ctrl are unchanged. Skid req bits are untouched.
  - resp_valid with out_ready = 1 in the same cycle: no capture; the consumer uses resp_data directly.
  - resp_valid with out_req = 0 or out_valid = 0: ignored.
- resp_held clears on pop. resp_reg holds its value until the next capture, flush or reset.
- A second resp_valid while resp_held = 1 cannot capture, because out_req is already 0.
- Flush (synchronous, highest priority): next cycle all entries are invalid, occupancy = 0, out_data/out_ctrl/out_req = 0, resp_held = 0, resp_reg = 0.
  - Flush discards any same-cycle accept, pop or capture.
  - in_ready is not gated by flush.
- Reset asserted mid-operation (mid-stall or mid-capture) clears all state immediately; no partial entry survives.
- occupancy = head_valid + skid_valid.

Test Plan:
1. Reset, then stream 4 entries (in_data = 1,2,3,4) with out_ready = 1 -> out_data = 1,2,3,4 on consecutive cycles, 1-cycle latency, occupancy ≤ 1.
2. SKID=1, out_ready = 0 for 3 cycles while offering A,B,C -> A in head, B in skid, C stalled (in_ready = 0, occupancy = 2). Release out_ready -> A,B,C emerge in order, no loss or duplicates.
3. Head with out_req = 2'b10, out_ready = 0, resp_valid = 1, resp_data = 32'hDEADBEEF -> next cycle resp_held = 1, resp_reg = DEADBEEF, out_req = 0. Later resp_valid pulses leave resp_reg unchanged. Pop clears resp_held.
4. resp_valid with out_ready = 1 on a head with out_req = 2'b01 -> no capture: resp_held = 0 and resp_reg keeps its prior value.
5. Occupancy 2 with a captured response, assert flush together with in_valid -> next cycle out_valid = 0, occupancy = 0, out_req = 0, resp_held = 0, resp_reg = 0, and the offered input is absent.
6. Pulse nRST low mid-stall (occupancy 2) -> all outputs 0 immediately; after release in_ready = 1 and the next accepted entry appears after 1 cycle.
